instr_fetch: RTL and testbench

//  Fetch/issue stage of the multi-cycle CPU; sits directly upstream of the Control decoder.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_timeout_ctr.sv | 29 ++
 rtl/instr_fetch.sv | 103 ++++++++++
 tb/tb_instr_fetch.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants used by fetch and Control, plus the fetch FSM encoding.
package cpu_pkg;

    localparam int unsigned OPW = 4;

    localparam logic [OPW-1:0] OP_FKEQ = 4'b0000;
    localparam logic [OPW-1:0] OP_JUMP = 4'b1010;
    localparam logic [OPW-1:0] OP_STOP = 4'b1110;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_HALT  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;

    function automatic logic is_stop(input logic [OPW-1:0] op);
        return op == OP_STOP;
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts FETCH cycles without ack; expired_c is high once TIMEOUT such cycles have elapsed.
module fetch_timeout_ctr #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Saturates at TIMEOUT so a stalled fetch cannot wrap back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired_c) begin
            count <= count + CW'(1);
        end
    end

    assign expired_c = (count == CW'(TIMEOUT));

endmodule

// File: rtl/instr_fetch.sv
// Fetch/issue stage: owns PC and IR, fetches over a level req/ack handshake, issues to Control.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned AW       = 8,
    parameter int unsigned IW       = 16,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned TIMEOUT  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_rdata,
    input  logic          imem_ack,
    input  logic          exec_done,
    input  logic          pc_load,
    input  logic [AW-1:0] pc_target,
    output logic [3:0]    opCode,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic          halted,
    output logic          fault
);

    fetch_state_t  state;
    logic [IW-1:0] ir;
    logic          expired_c;

    // Counter runs only across consecutive un-acked FETCH cycles.
    fetch_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear    ((state != ST_FETCH) || imem_ack),
        .enable   (state == ST_FETCH),
        .expired_c(expired_c)
    );

    assign opCode    = ir[IW-1 -: 4];
    assign instr     = ir;
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc          <= AW'(RESET_PC);
            ir          <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        imem_req <= 1'b1;
                        state    <= ST_FETCH;
                    end
                end
                // An ack arriving on the expiry cycle still wins over the timeout.
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir          <= imem_rdata;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= ST_ISSUE;
                    end else if (expired_c) begin
                        imem_req <= 1'b0;
                        fault    <= 1'b1;
                        state    <= ST_FAULT;
                    end
                end
                ST_ISSUE: begin
                    if (exec_done) begin
                        instr_valid <= 1'b0;
                        if (is_stop(opCode)) begin
                            halted <= 1'b1;
                            state  <= ST_HALT;
                        end else begin
                            pc       <= pc_load ? pc_target : pc + AW'(1);
                            imem_req <= 1'b1;
                            state    <= ST_FETCH;
                        end
                    end
                end
                ST_HALT, ST_FAULT: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected IR/address queued on ack, checked when issued.
module tb_instr_fetch;

    localparam int unsigned AW      = 8;
    localparam int unsigned IW      = 16;
    localparam int unsigned TIMEOUT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic          imem_ack;
    logic          exec_done;
    logic          pc_load;
    logic [AW-1:0] pc_target;
    logic [3:0]    opCode;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          halted;
    logic          fault;

    int checks = 0;
    int errors = 0;

    logic [IW-1:0] exp_ir_q[$];

    always #5 clk = ~clk;

    instr_fetch #(
        .AW(AW), .IW(IW), .RESET_PC(0), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .exec_done(exec_done), .pc_load(pc_load), .pc_target(pc_target),
        .opCode(opCode), .instr(instr), .instr_valid(instr_valid), .pc(pc),
        .halted(halted), .fault(fault)
    );

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        exec_done = 1'b0; pc_load = 1'b0; pc_target = '0;
        exp_ir_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for a request, holds ack off for 'delay' cycles, then acks and checks the issued word.
    task automatic fetch_one(input int delay, input logic [IW-1:0] data, input logic [AW-1:0] exp_addr);
        int n;
        logic [IW-1:0] exp_ir;
        n = 0;
        while (!imem_req && n < 4) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL req_wait: imem_req=%b required 1", imem_req);
        end
        for (int i = 0; i < delay; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
                errors++;
                $display("FAIL req_stable[%0d]: req=%b addr=%h required req=1 addr=%h", i, imem_req, imem_addr, exp_addr);
            end
            @(negedge clk);
        end
        checks++;
        if (imem_addr !== exp_addr) begin
            errors++;
            $display("FAIL fetch_addr: imem_addr=%h required %h", imem_addr, exp_addr);
        end
        imem_rdata = data;
        imem_ack   = 1'b1;
        exp_ir_q.push_back(data);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 16'hDEAD;
        exp_ir = exp_ir_q.pop_front();
        checks++;
        if (instr_valid !== 1'b1 || instr !== exp_ir || opCode !== exp_ir[15:12] || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL issue: valid=%b instr=%h op=%h req=%b required valid=1 instr=%h op=%h req=0",
                     instr_valid, instr, opCode, imem_req, exp_ir, exp_ir[15:12]);
        end
    endtask

    task automatic do_exec(input logic load, input logic [AW-1:0] target);
        exec_done = 1'b1; pc_load = load; pc_target = target;
        @(negedge clk);
        exec_done = 1'b0; pc_load = 1'b0; pc_target = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; imem_ack = 1'b0; exec_done = 1'b0; pc_load = 1'b0;
        imem_rdata = '0; pc_target = '0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 8'h00 || instr !== 16'h0000 ||
            halted !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL reset: req=%b valid=%b pc=%h instr=%h halted=%b fault=%b required all zero",
                     imem_req, instr_valid, pc, instr, halted, fault);
        end
        rst = 1'b0;
        @(negedge clk);
        // Redirects and exec_done in IDLE must be ignored.
        do_exec(1'b1, 8'h55);
        checks++;
        if (pc !== 8'h00 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: pc=%h req=%b required pc=00 req=0", pc, imem_req);
        end
    endtask

    task automatic test_basic_and_jump();
        do_reset();
        pulse_start();
        fetch_one(0, 16'h4123, 8'h00);
        do_exec(1'b0, 8'h00);
        checks++;
        if (pc !== 8'h01 || imem_req !== 1'b1 || imem_addr !== 8'h01 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL seq_pc: pc=%h req=%b addr=%h valid=%b required pc=01 req=1 addr=01 valid=0",
                     pc, imem_req, imem_addr, instr_valid);
        end
        fetch_one(0, 16'hA010, 8'h01);
        // pc_load without exec_done is ignored.
        pc_load = 1'b1; pc_target = 8'h77;
        @(negedge clk);
        pc_load = 1'b0;
        checks++;
        if (pc !== 8'h01 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL load_no_exec: pc=%h valid=%b req=%b required pc=01 valid=1 req=0", pc, instr_valid, imem_req);
        end
        do_exec(1'b1, 8'h10);
        checks++;
        if (pc !== 8'h10 || imem_addr !== 8'h10 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL jump: pc=%h addr=%h req=%b required pc=10 addr=10 req=1", pc, imem_addr, imem_req);
        end
        // start while fetching is ignored; the next fetch proceeds normally.
        pulse_start();
        fetch_one(0, 16'hE000, 8'h10);
        do_exec(1'b1, 8'h33);
        checks++;
        if (halted !== 1'b1 || pc !== 8'h10 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL stop: halted=%b pc=%h req=%b valid=%b required halted=1 pc=10 req=0 valid=0",
                     halted, pc, imem_req, instr_valid);
        end
    endtask

    task automatic test_halt_sticky();
        pulse_start();
        do_exec(1'b0, 8'h00);
        @(negedge clk);
        checks++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 8'h10 || fault !== 1'b0) begin
            errors++;
            $display("FAIL halt_sticky: halted=%b req=%b pc=%h fault=%b required halted=1 req=0 pc=10 fault=0",
                     halted, imem_req, pc, fault);
        end
    endtask

    task automatic test_delay_and_timeout();
        int n;
        do_reset();
        pulse_start();
        fetch_one(3, 16'h1234, 8'h00);
        do_exec(1'b0, 8'h00);
        // Ack on the very cycle the counter expires is still accepted.
        fetch_one(TIMEOUT, 16'h5678, 8'h01);
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL ack_at_timeout: fault=%b required 0", fault);
        end
        do_exec(1'b0, 8'h00);
        n = 0;
        while (imem_req === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != TIMEOUT + 1 || fault !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout: req_cycles=%0d fault=%b req=%b required req_cycles=%0d fault=1 req=0",
                     n, fault, imem_req, TIMEOUT + 1);
        end
        imem_ack = 1'b1; imem_rdata = 16'hBEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        pulse_start();
        checks++;
        if (instr !== 16'h5678 || instr_valid !== 1'b0 || fault !== 1'b1 || imem_req !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL late_ack: instr=%h valid=%b fault=%b req=%b halted=%b required instr=5678 valid=0 fault=1 req=0 halted=0",
                     instr, instr_valid, fault, imem_req, halted);
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        pulse_start();
        fetch_one(0, 16'hA0FF, 8'h00);
        do_exec(1'b1, 8'hFF);
        fetch_one(0, 16'h2000, 8'hFF);
        do_exec(1'b0, 8'h00);
        checks++;
        if (pc !== 8'h00 || imem_addr !== 8'h00 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL pc_wrap: pc=%h addr=%h req=%b required pc=00 addr=00 req=1", pc, imem_addr, imem_req);
        end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        pulse_start();
        fetch_one(0, 16'h4123, 8'h00);
        do_exec(1'b0, 8'h00);
        imem_ack = 1'b1; imem_rdata = 16'hBEEF;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || pc !== 8'h00 || instr !== 16'h0000) begin
            errors++;
            $display("FAIL rst_mid_fetch: req=%b pc=%h instr=%h required req=0 pc=00 instr=0000", imem_req, pc, instr);
        end
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 8'h00) begin
            errors++;
            $display("FAIL idle_after_rst: req=%b valid=%b pc=%h required req=0 valid=0 pc=00", imem_req, instr_valid, pc);
        end
        pulse_start();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL restart: req=%b addr=%h required req=1 addr=00", imem_req, imem_addr);
        end
        fetch_one(0, 16'h3456, 8'h00);
    endtask

    initial begin
        test_reset();
        test_basic_and_jump();
        test_halt_sticky();
        test_delay_and_timeout();
        test_pc_wrap();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
